p2s_serializer: RTL and testbench

P2S_SERIALIZER -- requirements
Module: p2s_serializer

---
 rtl/p2s_serializer.sv | 113 +++++++++++
 tb/tb_p2s_serializer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/p2s_serializer.sv
// p2s_serializer: parallel-in / serial-out shifter with a simultaneous
// serial-in capture path. Each bit is held for DIV clocks. Outputs are
// decoded from the state and the shift register, so they appear one
// cycle after the edge that starts a transfer.
module p2s_serializer #(
    parameter int WIDTH     = 16,
    parameter int DIV       = 1,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] p_in,
    input  logic             s_in,
    output logic             s_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] q
);

    localparam int CW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, REARM} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tx_sr, rx_sr, rx_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic             bit_end, last_bit;

    assign bit_end  = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

    // Received bits enter from the side that keeps them in transmit order.
    assign rx_nxt = LSB_FIRST ? {s_in, rx_sr[WIDTH-1:1]}
                              : {rx_sr[WIDTH-2:0], s_in};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and output decode; the line idles high outside SHIFT.
    always_comb begin
        state_nxt  = state;
        s_out      = 1'b1;
        bit_strobe = 1'b0;
        busy       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy       = 1'b1;
                s_out      = LSB_FIRST ? tx_sr[0] : tx_sr[WIDTH-1];
                bit_strobe = (div_cnt == '0);
                if (bit_end && last_bit) state_nxt = DONE;
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = start ? REARM : IDLE;
            end
            REARM: begin
                // A held-high start must drop before another transfer.
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: word capture, bit/divider counters, tx/rx shifting, q load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    rx_sr   <= '0;
                    if (start) tx_sr <= p_in;
                end
                SHIFT: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        tx_sr   <= LSB_FIRST ? (tx_sr >> 1) : (tx_sr << 1);
                        rx_sr   <= rx_nxt;
                        if (last_bit) begin
                            bit_cnt <= '0;
                            q       <= rx_nxt;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_p2s_serializer.sv
// Directed bench for p2s_serializer: MSB-first and LSB-first DIV=1 units
// share one stimulus, a DIV=4 unit has its own. Each s_in is looped back
// from its own s_out so q must reproduce the transmitted word.
module tb_p2s_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_d;
    logic [15:0] p_a, p_d;
    logic        so_m, st_m, bz_m, fn_m;
    logic        so_l, st_l, bz_l, fn_l;
    logic        so_d, st_d, bz_d, fn_d;
    logic [15:0] q_m, q_l, q_d;

    p2s_serializer #(.WIDTH(16), .DIV(1), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .start(start_a), .p_in(p_a), .s_in(so_m),
        .s_out(so_m), .bit_strobe(st_m), .busy(bz_m), .finish(fn_m), .q(q_m));

    p2s_serializer #(.WIDTH(16), .DIV(1), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .start(start_a), .p_in(p_a), .s_in(so_l),
        .s_out(so_l), .bit_strobe(st_l), .busy(bz_l), .finish(fn_l), .q(q_l));

    p2s_serializer #(.WIDTH(16), .DIV(4), .LSB_FIRST(1'b0)) u_div (
        .clk(clk), .rst(rst), .start(start_d), .p_in(p_d), .s_in(so_d),
        .s_out(so_d), .bit_strobe(st_d), .busy(bz_d), .finish(fn_d), .q(q_d));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line vectors are {s_out, bit_strobe, busy, finish}.
    initial begin
        logic [15:0] seq_m, seq_l, w;
        int          strobes;

        rst = 1'b0; start_a = 1'b0; start_d = 1'b0; p_a = '0; p_d = '0;
        repeat (2) @(negedge clk);
        chk("rst_line_m", {so_m, st_m, bz_m, fn_m}, 4'b1000);
        chk("rst_line_l", {so_l, st_l, bz_l, fn_l}, 4'b1000);
        chk("rst_line_d", {so_d, st_d, bz_d, fn_d}, 4'b1000);
        chk("rst_q_m", q_m, 16'h0000);
        chk("rst_q_l", q_l, 16'h0000);
        chk("rst_q_d", q_d, 16'h0000);

        // Held-high start, 16'h9571, both bit orders.
        seq_m = 16'b1001_0101_0111_0001;
        seq_l = 16'b1000_1110_1010_1001;
        p_a = 16'h9571; start_a = 1'b1; rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("a_bit_m", {so_m, st_m, bz_m, fn_m}, {seq_m[15-i], 3'b110});
            chk("a_bit_l", {so_l, st_l, bz_l, fn_l}, {seq_l[15-i], 3'b110});
        end
        @(negedge clk);
        chk("a_done_m", {so_m, st_m, bz_m, fn_m}, 4'b1001);
        chk("a_done_l", {so_l, st_l, bz_l, fn_l}, 4'b1001);
        chk("a_q_m", q_m, 16'h9571);
        chk("a_q_l", q_l, 16'h9571);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("a_rearm_m", {so_m, st_m, bz_m, fn_m}, 4'b1000);
            chk("a_rearm_l", {so_l, st_l, bz_l, fn_l}, 4'b1000);
        end
        chk("a_div_idle", {so_d, st_d, bz_d, fn_d}, 4'b1000);
        start_a = 1'b0;
        @(negedge clk);
        chk("a_idle_m", {so_m, st_m, bz_m, fn_m}, 4'b1000);
        chk("a_hold_q_m", q_m, 16'h9571);

        // 16'hA5C3 loopback; p_in and start wiggle during SHIFT.
        w = 16'hA5C3;
        p_a = w; start_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("b_bit_m", {so_m, st_m, bz_m, fn_m}, {w[15-i], 3'b110});
            chk("b_bit_l", {so_l, st_l, bz_l, fn_l}, {w[i], 3'b110});
            if (i == 0)  start_a = 1'b0;
            if (i == 4)  p_a = 16'hFFFF;
            if (i == 8)  start_a = 1'b1;
            if (i == 10) start_a = 1'b0;
        end
        @(negedge clk);
        chk("b_done_m", {so_m, st_m, bz_m, fn_m}, 4'b1001);
        chk("b_q_m", q_m, 16'hA5C3);
        chk("b_q_l", q_l, 16'hA5C3);
        @(negedge clk);
        chk("b_idle_m", {so_m, st_m, bz_m, fn_m}, 4'b1000);
        chk("b_idle_l", {so_l, st_l, bz_l, fn_l}, 4'b1000);
        @(negedge clk);
        chk("b_stay_idle_m", {so_m, st_m, bz_m, fn_m}, 4'b1000);
        chk("b_hold_q_l", q_l, 16'hA5C3);

        // Reset after bit 7, then a fresh transfer with start held.
        w = 16'h3C5A;
        p_a = w; start_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("c_pre_bit_m", {so_m, st_m, bz_m, fn_m}, {w[15-i], 3'b110});
        end
        rst = 1'b0;
        @(negedge clk);
        chk("c_abort_m", {so_m, st_m, bz_m, fn_m}, 4'b1000);
        chk("c_abort_l", {so_l, st_l, bz_l, fn_l}, 4'b1000);
        chk("c_abort_q_m", q_m, 16'h0000);
        chk("c_abort_q_l", q_l, 16'h0000);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("c_bit_m", {so_m, st_m, bz_m, fn_m}, {w[15-i], 3'b110});
            chk("c_bit_l", {so_l, st_l, bz_l, fn_l}, {w[i], 3'b110});
        end
        @(negedge clk);
        chk("c_done_m", {so_m, st_m, bz_m, fn_m}, 4'b1001);
        chk("c_q_m", q_m, 16'h3C5A);
        chk("c_q_l", q_l, 16'h3C5A);
        start_a = 1'b0;
        @(negedge clk);
        chk("c_idle_m", {so_m, st_m, bz_m, fn_m}, 4'b1000);

        // DIV=4, 16'hF0F0: 64 busy cycles, strobe every 4th.
        w = 16'hF0F0;
        strobes = 0;
        p_d = w; start_d = 1'b1;
        for (int c = 0; c < 64; c++) begin
            int idx;
            idx = 15 - c / 4;
            @(negedge clk);
            chk("d_line", {so_d, st_d, bz_d, fn_d}, {w[idx], (c % 4 == 0), 2'b10});
            if (st_d) strobes++;
            if (c == 20) p_d = 16'h0000;
        end
        chk("d_strobes", strobes, 16);
        @(negedge clk);
        chk("d_done", {so_d, st_d, bz_d, fn_d}, 4'b1001);
        chk("d_q", q_d, 16'hF0F0);
        chk("d_other_idle", {so_m, st_m, bz_m, fn_m}, 4'b1000);
        @(negedge clk);
        chk("d_rearm", {so_d, st_d, bz_d, fn_d}, 4'b1000);
        start_d = 1'b0;
        @(negedge clk);
        chk("d_idle", {so_d, st_d, bz_d, fn_d}, 4'b1000);
        chk("d_hold_q", q_d, 16'hF0F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
